player_move_ctrl: RTL and testbench
===================================

# player_move_ctrl

Player movement controller sitting directly downstream of the grid enable-compare stage. It takes the four aggregated move enables (up/down/left/right, each high only when every scroll block permits the move) and the raw direction buttons, and produces the registered player sprite position consumed by the VGA drawing logic. Buttons are synchronised and debounced, a direction is latched by a small FSM, and position steps once per frame tick while the move is permitted and in bounds.

## Interface
- X_W, 10, width of pos_x
- Y_W, 10, width of pos_y
- X_MIN / X_MAX, 0 / 620, inclusive horizontal bounds of pos_x
- Y_MIN / Y_MAX, 0 / 460, inclusive vertical bounds of pos_y
- X_INIT / Y_INIT, 320 / 240, reset position
- STEP, 4, pixels moved per accepted frame tick
- DB_CYCLES, 16'd50000, clocks a synced button must be stable before its debounced level changes
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw asynchronous push buttons, active high
- upEnable_o, downEnable_o, leftEnable_o, rightEnable_o  in  1 each  move permits from the enable-compare stage (combinational, valid every cycle)
- frame_tick  in  1  one-clock pulse per video frame
- pos_x  out  X_W  registered player x
- pos_y  out  Y_W  registered player y
- dir  out  2  latched direction: 0 up, 1 down, 2 left, 3 right
- moving  out  1  high while FSM in MOVE
- blocked  out  1  high while FSM in BLOCKED
- step_cnt  out  16  count of accepted steps, wraps 16'hFFFF -> 0

## Operation
- Each button: 2-flop synchroniser, then debounce counter; debounced level takes the synced value once it has differed from the current debounced level for DB_CYCLES consecutive clocks; any bounce back clears the counter.
- Request priority among debounced buttons: up > down > left > right.
- "Permitted" for direction d: matching enable input high AND position not already at the bound in direction d (up: pos_y==Y_MIN, down: pos_y==Y_MAX, left: pos_x==X_MIN, right: pos_x==X_MAX).
- Step arithmetic saturates: up pos_y = max(pos_y-STEP, Y_MIN); down min(pos_y+STEP, Y_MAX); left/right likewise on pos_x. Computed at X_W+1/Y_W+1 bits, no wrap.
- FSM states IDLE, MOVE, BLOCKED; transitions evaluated only on frame_tick cycles, otherwise hold.
- IDLE: if any debounced button high, latch dir = highest-priority one; if permitted, step, step_cnt+1, go MOVE; else go BLOCKED. No button: stay.
- MOVE: latched button released -> IDLE (no step). Held and permitted -> step, stay. Held and not permitted -> BLOCKED (no step).
- BLOCKED: latched button released -> IDLE. Held and permitted -> step, go MOVE. Otherwise stay.
- Direction changes only via IDLE; other buttons pressed while latched are ignored.
- Enables are sampled on the frame_tick cycle only.

## Timing
- Reset (async assert, sync-free): pos_x=X_INIT, pos_y=Y_INIT, dir=0, moving=0, blocked=0, step_cnt=0, state IDLE, synchroniser flops and debounce levels 0, debounce counters 0.
- Reset asserted mid-move clears everything immediately; first frame_tick after release sees IDLE.
- Button-to-debounced latency: 2 + DB_CYCLES clocks.
- Position/step_cnt/state/dir/moving/blocked update on the clock edge ending the frame_tick cycle; visible one cycle after frame_tick.
- At most one step per frame_tick; back-to-back frame_tick pulses each evaluated independently.
- Button release and frame_tick in the same cycle: release wins (no step).

## Test plan
- Reset with DB_CYCLES=4: pos=(320,240), all flags 0; hold btn_right, all enables 1, 3 frame_ticks after debounce -> pos_x 324, 328, 332; moving=1, dir=3, step_cnt=3.
- Right held, rightEnable_o dropped before tick 2 -> no step on tick 2, blocked=1, moving=0; enable back high on tick 3 -> pos_x +4, moving=1.
- Start pos_y=2 via Y_INIT, hold up -> pos_y 0 (saturate), next tick BLOCKED, pos_y stays 0.
- btn_up and btn_left pressed together -> dir=0; release up, keep left -> IDLE on next tick, following tick dir=2 and pos_x-4.
- Button bouncing with pulses shorter than DB_CYCLES -> debounced level unchanged, no movement.
- Assert rst_n low mid-MOVE between ticks -> outputs return to reset values in the same cycle, step_cnt=0.

Source files
------------

// File: rtl/player_move_ctrl.sv
// player_move_ctrl: debounced direction buttons drive a
// small FSM that steps the player sprite once per frame tick.
module player_move_ctrl #(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 620,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 460,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int STEP   = 4,
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           btn_up,
  input  logic           btn_down,
  input  logic           btn_left,
  input  logic           btn_right,
  input  logic           upEnable_o,
  input  logic           downEnable_o,
  input  logic           leftEnable_o,
  input  logic           rightEnable_o,
  input  logic           frame_tick,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic [1:0]     dir,
  output logic           moving,
  output logic           blocked,
  output logic [15:0]    step_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE    = 2'd1,
    BLOCKED = 2'd2
  } stateT;

  localparam logic [X_W:0] xMinW  = (X_W+1)'(X_MIN);
  localparam logic [X_W:0] xMaxW  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] xStepW = (X_W+1)'(STEP);
  localparam logic [Y_W:0] yMinW  = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0] yMaxW  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] yStepW = (Y_W+1)'(STEP);

  localparam logic [X_W-1:0] xMinN  = X_W'(X_MIN);
  localparam logic [X_W-1:0] xMaxN  = X_W'(X_MAX);
  localparam logic [X_W-1:0] xInitN = X_W'(X_INIT);
  localparam logic [Y_W-1:0] yMinN  = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] yMaxN  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] yInitN = Y_W'(Y_INIT);

  // bit order everywhere: 0 up, 1 down, 2 left, 3 right
  logic [3:0]  btnRaw;
  logic [3:0]  sync0;
  logic [3:0]  sync1;
  logic [3:0]  dbLevel;
  logic [15:0] dbCnt [4];
  logic [3:0]  enVec;
  logic [3:0]  atBound;

  stateT       state;
  stateT       stateNext;
  logic [1:0]  dirNext;
  logic [1:0]  reqDir;
  logic        anyReq;
  logic [1:0]  evalDir;
  logic        permit;
  logic        held;
  logic        doStep;

  logic [X_W:0]   xWide;
  logic [X_W:0]   xSum;
  logic [Y_W:0]   yWide;
  logic [Y_W:0]   ySum;
  logic [X_W-1:0] leftX;
  logic [X_W-1:0] rightX;
  logic [Y_W-1:0] upY;
  logic [Y_W-1:0] downY;
  logic [X_W-1:0] xNext;
  logic [Y_W-1:0] yNext;

  assign btnRaw = {btn_right, btn_left, btn_down, btn_up};
  assign enVec  = {rightEnable_o, leftEnable_o,
                   downEnable_o, upEnable_o};

  // two-flop synchroniser for the raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= btnRaw;
      sync1 <= sync0;
    end
  end

  // debounce: adopt synced level after DB_CYCLES stable clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbLevel <= '0;
      for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync1[i] != dbLevel[i]) begin
          if (dbCnt[i] == DB_CYCLES - 16'd1) begin
            dbLevel[i] <= sync1[i];
            dbCnt[i]   <= '0;
          end else begin
            dbCnt[i] <= dbCnt[i] + 16'd1;
          end
        end else begin
          dbCnt[i] <= '0;
        end
      end
    end
  end

  // fixed-priority request pick: up > down > left > right
  always_comb begin
    reqDir = 2'd0;
    anyReq = |dbLevel;
    if (dbLevel[0])      reqDir = 2'd0;
    else if (dbLevel[1]) reqDir = 2'd1;
    else if (dbLevel[2]) reqDir = 2'd2;
    else if (dbLevel[3]) reqDir = 2'd3;
  end

  // bound detection and saturating step candidates
  always_comb begin
    atBound[0] = (pos_y == yMinN);
    atBound[1] = (pos_y == yMaxN);
    atBound[2] = (pos_x == xMinN);
    atBound[3] = (pos_x == xMaxN);
    xWide  = {1'b0, pos_x};
    yWide  = {1'b0, pos_y};
    xSum   = xWide + xStepW;
    ySum   = yWide + yStepW;
    leftX  = (xWide >= xMinW + xStepW)
           ? X_W'(xWide - xStepW) : xMinN;
    rightX = (xSum > xMaxW) ? xMaxN : X_W'(xSum);
    upY    = (yWide >= yMinW + yStepW)
           ? Y_W'(yWide - yStepW) : yMinN;
    downY  = (ySum > yMaxW) ? yMaxN : Y_W'(ySum);
  end

  assign evalDir = (state == IDLE) ? reqDir : dir;
  assign permit  = enVec[evalDir] && !atBound[evalDir];
  assign held    = dbLevel[dir];

  // next state and step decision, only on frame_tick
  always_comb begin
    stateNext = state;
    dirNext   = dir;
    doStep    = 1'b0;
    if (frame_tick) begin
      unique case (state)
        IDLE: begin
          if (anyReq) begin
            dirNext = reqDir;
            if (permit) begin
              doStep    = 1'b1;
              stateNext = MOVE;
            end else begin
              stateNext = BLOCKED;
            end
          end
        end
        MOVE: begin
          if (!held)       stateNext = IDLE;
          else if (permit) doStep    = 1'b1;
          else             stateNext = BLOCKED;
        end
        BLOCKED: begin
          if (!held) begin
            stateNext = IDLE;
          end else if (permit) begin
            doStep    = 1'b1;
            stateNext = MOVE;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // pick the stepped coordinate for the evaluated direction
  always_comb begin
    xNext = pos_x;
    yNext = pos_y;
    if (doStep) begin
      unique case (evalDir)
        2'd0: yNext = upY;
        2'd1: yNext = downY;
        2'd2: xNext = leftX;
        2'd3: xNext = rightX;
        default: ;
      endcase
    end
  end

  // state, direction, position and step counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dir      <= 2'd0;
      pos_x    <= xInitN;
      pos_y    <= yInitN;
      step_cnt <= '0;
    end else begin
      state <= stateNext;
      dir   <= dirNext;
      pos_x <= xNext;
      pos_y <= yNext;
      if (doStep) step_cnt <= step_cnt + 16'd1;
    end
  end

  assign moving  = (state == MOVE);
  assign blocked = (state == BLOCKED);

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb_player_move_ctrl: directed plus random checks of the
// movement controller against a rule-level model.
module tb_player_move_ctrl;

  localparam int DB = 4;
  localparam int XMAX = 620;
  localparam int YMAX = 460;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  logic [3:0] btnV = '0;
  logic [3:0] enV = 4'hF;
  logic frame_tick = 1'b0;

  logic [9:0]  posX, posY, posX2, posY2;
  logic [1:0]  dirO, dir2;
  logic        movingO, blockedO, moving2, blocked2;
  logic [15:0] stepCnt, stepCnt2;

  int errors = 0;
  int checks = 0;

  int mx, my, mdir, mcnt;
  bit mMoving, mBlocked;

  always #5 clk = ~clk;

  player_move_ctrl #(.DB_CYCLES(16'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btnV[0]), .btn_down(btnV[1]),
    .btn_left(btnV[2]), .btn_right(btnV[3]),
    .upEnable_o(enV[0]), .downEnable_o(enV[1]),
    .leftEnable_o(enV[2]), .rightEnable_o(enV[3]),
    .frame_tick(frame_tick),
    .pos_x(posX), .pos_y(posY), .dir(dirO),
    .moving(movingO), .blocked(blockedO),
    .step_cnt(stepCnt)
  );

  player_move_ctrl #(.DB_CYCLES(16'd4), .Y_INIT(2)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .btn_up(btnV[0]), .btn_down(btnV[1]),
    .btn_left(btnV[2]), .btn_right(btnV[3]),
    .upEnable_o(enV[0]), .downEnable_o(enV[1]),
    .leftEnable_o(enV[2]), .rightEnable_o(enV[3]),
    .frame_tick(frame_tick),
    .pos_x(posX2), .pos_y(posY2), .dir(dir2),
    .moving(moving2), .blocked(blocked2),
    .step_cnt(stepCnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".pos_x"}, 32'(posX), mx);
    chk({tag, ".pos_y"}, 32'(posY), my);
    chk({tag, ".dir"}, 32'(dirO), mdir);
    chk({tag, ".moving"}, 32'(movingO), 32'(mMoving));
    chk({tag, ".blocked"}, 32'(blockedO), 32'(mBlocked));
    chk({tag, ".step_cnt"}, 32'(stepCnt), mcnt);
  endtask

  task automatic modelReset();
    mx = 320; my = 240; mdir = 0; mcnt = 0;
    mMoving = 0; mBlocked = 0;
  endtask

  function automatic bit allowed(input int d);
    case (d)
      0: return enV[0] && my != 0;
      1: return enV[1] && my != YMAX;
      2: return enV[2] && mx != 0;
      default: return enV[3] && mx != XMAX;
    endcase
  endfunction

  task automatic stepModel(input int d);
    case (d)
      0: my = (my - 4 < 0) ? 0 : my - 4;
      1: my = (my + 4 > YMAX) ? YMAX : my + 4;
      2: mx = (mx - 4 < 0) ? 0 : mx - 4;
      default: mx = (mx + 4 > XMAX) ? XMAX : mx + 4;
    endcase
    mcnt = (mcnt + 1) % 65536;
  endtask

  // buttons are settled whenever a tick is issued
  task automatic modelTick();
    if (!mMoving && !mBlocked) begin
      if (btnV != 0) begin
        mdir = btnV[0] ? 0 : btnV[1] ? 1 : btnV[2] ? 2 : 3;
        if (allowed(mdir)) begin
          stepModel(mdir);
          mMoving = 1;
        end else begin
          mBlocked = 1;
        end
      end
    end else if (!btnV[mdir]) begin
      mMoving = 0; mBlocked = 0;
    end else if (allowed(mdir)) begin
      stepModel(mdir);
      mMoving = 1; mBlocked = 0;
    end else begin
      mMoving = 0; mBlocked = 1;
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    modelTick();
    checkAll(tag);
  endtask

  task automatic setBtn(input logic [3:0] v);
    @(negedge clk) btnV = v;
    repeat (DB + 4) @(negedge clk);
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;

    setBtn(4'b1000);
    repeat (3) tick("right");
    chk("right3.pos_x", 32'(posX), 332);
    chk("right3.dir", 32'(dirO), 3);
    chk("right3.cnt", 32'(stepCnt), 3);

    enV = 4'b0111;
    tick("rdrop");
    chk("rdrop.blocked", 32'(blockedO), 1);
    enV = 4'hF;
    tick("rback");
    chk("rback.pos_x", 32'(posX), 336);

    setBtn(4'b0000);
    tick("rel");
    setBtn(4'b0101);
    tick("upleft");
    chk("upleft.dir", 32'(dirO), 0);
    setBtn(4'b0100);
    tick("leftonly1");
    tick("leftonly2");
    chk("leftonly.dir", 32'(dirO), 2);

    setBtn(4'b0000);
    tick("idle");
    for (int k = 0; k < 12; k++) begin
      @(negedge clk) btnV[1] = 1'b1;
      repeat ($urandom_range(1, DB - 1)) @(negedge clk);
      btnV[1] = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (DB + 4) @(negedge clk);
    tick("bounce1");
    tick("bounce2");

    setBtn(4'b0100);
    repeat (85) tick("toleft");
    chk("toleft.pos_x", 32'(posX), 0);
    chk("toleft.blocked", 32'(blockedO), 1);
    setBtn(4'b0000);
    tick("rel2");
    setBtn(4'b1000);
    repeat (160) tick("toright");
    chk("toright.pos_x", 32'(posX), XMAX);

    for (int it = 0; it < 60; it++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        v = 4'(1 << $urandom_range(0, 3));
      setBtn(v);
      repeat ($urandom_range(1, 6)) begin
        for (int b = 0; b < 4; b++)
          enV[b] = ($urandom_range(0, 3) != 0);
        tick("rand");
      end
    end

    enV = 4'hF;
    setBtn(4'b0000);
    tick("prerst");
    if (mx == 0) setBtn(4'b1000);
    else setBtn(4'b0100);
    tick("premove");
    chk("premove.moving", 32'(movingO), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("rstmid");
    @(negedge clk) rst_n = 1'b1;
    repeat (DB + 4) @(negedge clk);
    tick("afterrst");

    setBtn(4'b0000);
    @(negedge clk) rst2_n = 1'b1;
    #1;
    chk("y2.reset_y", 32'(posY2), 2);
    chk("y2.reset_x", 32'(posX2), 320);
    setBtn(4'b0001);
    tick("y2main1");
    chk("y2.sat_y", 32'(posY2), 0);
    chk("y2.moving", 32'(moving2), 1);
    chk("y2.cnt", 32'(stepCnt2), 1);
    tick("y2main2");
    chk("y2.blocked", 32'(blocked2), 1);
    chk("y2.hold_y", 32'(posY2), 0);
    chk("y2.dir", 32'(dir2), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
